// File: rtl/kc_ls1u_core_g2.sv
// kc_ls1u_core_g2 -- second-generation KC-LS1u core.
//
// Purpose: 16-bit-instruction CPU core with a DW-wide datapath built from
// 74181-style ALU slices, a handshaked data bus and prioritised nested
// interrupts backed by a hardware return stack.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   WAIT                external stall
//   INT, INTCODE        level interrupt request and its source code
//                       (lower code = higher priority)
//   IVT_addr            interrupt vector table base
//   int_ack             pulse in the cycle an interrupt is vectored
//   int_level           current nesting depth
//   iaddr / instr       fetch address (PC) / instruction
//   daddr               {A2,A1,A0}
//   dread / dwrite      load / store in progress
//   ddata_i / ddata_o   load data / store data (MDR)
//   dready              completion of the current bus access
//
// Configuration macro: KC_LS1U_G2_NEST_EN
//   defined   -> nested, prioritised interrupts up to RET_DEPTH deep
//   undefined -> single level; further interrupts masked until RET

// One 4-bit 74181 slice, active-high data, active-high carry.
// t1/t2 are the chip's two internal per-bit terms: arithmetic mode adds
// them, logic mode outputs their XNOR.
module kc_ls1u_g2_alu181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
    output logic       eqv
);
    logic [3:0] t1;
    logic [3:0] t2;
    logic [4:0] sum;

    always_comb begin
        t1   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t2   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum  = {1'b0, t1} + {1'b0, t2} + {4'b0000, cin};
        f    = m ? ~(t1 ^ t2) : sum[3:0];
        cout = sum[4];
        eqv  = &f;
    end
endmodule

module kc_ls1u_core_g2 #(
    parameter  int DW        = 8,
    parameter  int RET_DEPTH = 4,
    parameter  int CW        = 6,
    localparam int AW        = 3 * DW,
    localparam int LW        = $clog2(RET_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WAIT,
    input  logic          INT,
    input  logic [CW-1:0] INTCODE,
    input  logic [AW-1:0] IVT_addr,
    output logic          int_ack,
    output logic [LW-1:0] int_level,
    output logic [AW-1:0] iaddr,
    input  logic [15:0]   instr,
    output logic [AW-1:0] daddr,
    output logic          dread,
    output logic          dwrite,
    input  logic [DW-1:0] ddata_i,
    output logic [DW-1:0] ddata_o,
    input  logic          dready
);
    // Stack index width; arrays are rounded up to a power of two so any
    // index value is in range.
    localparam int IW = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
    localparam int SD = 2 ** IW;
`ifdef KC_LS1U_G2_NEST_EN
    localparam int DEPTH = RET_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int NS = DW / 4;

    // Register file: 0 C, 1 A, 2 B, 3 A0, 4 A1, 5 A2, 6 D, 7 MDR
    logic [DW-1:0] regs [8];
    logic [AW-1:0] pc;

    logic [AW-1:0] ret_addr [SD];
`ifdef KC_LS1U_G2_NEST_EN
    logic [CW-1:0] ret_code [SD];
`endif

    logic [4:0]    funct5;
    logic [2:0]    dst;
    logic [DW-1:0] ra, rb;
    logic [DW-1:0] alu_f;
    logic [NS:0]   carry;
    logic [NS-1:0] eqv;
    logic          alu_co, alu_eq;
    logic          wr_en, is_load, is_jmp, is_ret, jmp_cond, jmp_taken;
    logic [DW-1:0] wr_data;
    logic          stall, prio_ok, accept;
    logic [AW-1:0] jmp_target, seq_pc, vector;
    logic [IW-1:0] push_idx, top_idx;
    logic          unused_ok;

    assign funct5    = instr[15:11];
    assign dst       = instr[10:8];
    assign ra        = regs[1];
    assign rb        = regs[2];
    assign unused_ok = &{1'b0, instr[1:0]};

    // Ripple-carry ALU from 4-bit slices; slice 0 carry-in is instr[2].
    assign carry[0] = instr[2];
    for (genvar k = 0; k < NS; k++) begin : g_slice
        kc_ls1u_g2_alu181 u_slice (
            .a    (ra[4*k +: 4]),
            .b    (rb[4*k +: 4]),
            .s    (instr[7:4]),
            .m    (instr[3]),
            .cin  (carry[k]),
            .f    (alu_f[4*k +: 4]),
            .cout (carry[k+1]),
            .eqv  (eqv[k])
        );
    end
    assign alu_co = carry[NS];
    assign alu_eq = &eqv;

    // Instruction decode and writeback data
    always_comb begin
        wr_en   = 1'b1;
        wr_data = '0;
        is_load = 1'b0;
        is_jmp  = 1'b0;
        case (funct5)
            5'h01: begin wr_en = 1'b0; is_jmp = 1'b1; end
            5'h02: wr_data = alu_f;
            5'h04: begin is_load = 1'b1; wr_data = ddata_i; end
            5'h05: wr_data = regs[0];
            5'h06: wr_data = DW'(instr[7:0]);
            5'h07: wr_data = regs[6];
            5'h0D: wr_data = {ra[DW-2:0], 1'b0};
            5'h10: wr_data = {ra[DW-2:0], rb[DW-1]};
            5'h12: wr_data = {1'b0, ra[DW-1:1]};
            5'h14: wr_data = {ra[DW-1], ra[DW-1:1]};
            5'h16: wr_data = {rb[DW-2:0], 1'b0};
            5'h18: wr_data = {1'b0, rb[DW-1:1]};
            5'h1A: wr_data = {rb[DW-1], rb[DW-1:1]};
            5'h1C: wr_data = {ra[0], rb[DW-1:1]};
            default: wr_en = 1'b0;
        endcase
    end

    always_comb begin
        jmp_cond = 1'b0;
        case (dst)
            3'd1:    jmp_cond = ~ra[DW-1];
            3'd2:    jmp_cond = ~rb[DW-1];
            3'd3:    jmp_cond = ~alu_eq;
            3'd4:    jmp_cond = ~alu_co;
            default: jmp_cond = 1'b0;
        endcase
    end

    assign is_ret     = is_jmp & (dst == 3'd0);
    assign jmp_taken  = is_jmp & jmp_cond;
    assign jmp_target = {regs[5], regs[4], regs[3]};
    // Return address for an interrupt follows a taken jump.
    assign seq_pc     = jmp_taken ? jmp_target : pc + AW'(1);
    assign vector     = IVT_addr + (AW'(INTCODE) << 2);

    assign stall = WAIT | (is_load & ~dready) | (dwrite & ~dready);

    assign push_idx = IW'(int_level);
    assign top_idx  = IW'(int_level - LW'(1));
`ifdef KC_LS1U_G2_NEST_EN
    assign prio_ok = (int_level == '0) || (INTCODE < ret_code[top_idx]);
`else
    assign prio_ok = 1'b1;
`endif
    assign accept = INT & ~stall & ~is_ret & (int_level < LW'(DEPTH)) & prio_ok;

    assign int_ack = accept & ~rst;
    assign iaddr   = pc;
    assign daddr   = jmp_target;
    assign dread   = is_load;
    assign ddata_o = regs[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            int_level <= '0;
            dwrite    <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            for (int i = 0; i < SD; i++) begin
                ret_addr[i] <= '0;
`ifdef KC_LS1U_G2_NEST_EN
                ret_code[i] <= '0;
`endif
            end
        end else begin
            if (dwrite && dready) dwrite <= 1'b0;
            if (!stall) begin
                if (wr_en) regs[dst] <= wr_data;
                // A new MDR value starts a store next cycle; this wins over
                // the completion clear above.
                if (wr_en && dst == 3'd7) dwrite <= 1'b1;
                if (accept) begin
                    ret_addr[push_idx] <= seq_pc;
`ifdef KC_LS1U_G2_NEST_EN
                    ret_code[push_idx] <= INTCODE;
`endif
                    int_level <= int_level + LW'(1);
                    pc        <= vector;
                end else if (is_ret) begin
                    // RET with an empty stack goes to the fault vector 0.
                    if (int_level != '0) begin
                        pc        <= ret_addr[top_idx];
                        int_level <= int_level - LW'(1);
                    end else begin
                        pc <= '0;
                    end
                end else begin
                    pc <= seq_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_kc_ls1u_core_g2.sv
// Self-checking bench for kc_ls1u_core_g2 (DW=8, RET_DEPTH=2).
// A cycle-level reference model (whole-word ALU from the 74181 function
// table, return stack as a queue) predicts every visible output.
module tb_kc_ls1u_core_g2;
    localparam int DW = 8;
    localparam int RD = 2;
    localparam int CW = 6;
    localparam int AW = 3 * DW;
    localparam int LW = $clog2(RD + 1);
`ifdef KC_LS1U_G2_NEST_EN
    localparam bit NEST  = 1'b1;
    localparam int EFF_D = RD;
`else
    localparam bit NEST  = 1'b0;
    localparam int EFF_D = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, WAIT, INT, dready;
    logic [CW-1:0] INTCODE;
    logic [AW-1:0] IVT_addr, iaddr, daddr;
    logic          int_ack, dread, dwrite;
    logic [LW-1:0] int_level;
    logic [15:0]   instr;
    logic [DW-1:0] ddata_i, ddata_o;

    always #5 clk = ~clk;

    kc_ls1u_core_g2 #(.DW(DW), .RET_DEPTH(RD), .CW(CW)) dut (
        .clk(clk), .rst(rst), .WAIT(WAIT), .INT(INT), .INTCODE(INTCODE),
        .IVT_addr(IVT_addr), .int_ack(int_ack), .int_level(int_level),
        .iaddr(iaddr), .instr(instr), .daddr(daddr), .dread(dread),
        .dwrite(dwrite), .ddata_i(ddata_i), .ddata_o(ddata_o), .dready(dready)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int stepno = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] code;
    } frame_t;

    frame_t        stk[$];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_r [8];
    bit            m_dw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, got, exp);
        end
    endtask

    task automatic mreset();
        m_pc = '0;
        m_dw = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        stk.delete();
    endtask

    function automatic logic [15:0] op(input int f5, input int d, input int lo);
        logic [15:0] r;
        r = {5'(f5), 3'(d), 8'(lo)};
        return r;
    endfunction

    // Whole-word 74181 function table (active-high data and carry).
    task automatic alu_ref(input logic [3:0] s, input bit m, input bit c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] f, output bit co, output bit eq);
        longint la, lb, nb, ones, r, lg;
        ones = (longint'(1) << DW) - 1;
        la = longint'(a);
        lb = longint'(b);
        nb = ~lb & ones;
        case (s)
            4'd0:  r = la;
            4'd1:  r = la | lb;
            4'd2:  r = la | nb;
            4'd3:  r = ones;
            4'd4:  r = la + (la & nb);
            4'd5:  r = (la | lb) + (la & nb);
            4'd6:  r = la + nb;
            4'd7:  r = (la & nb) + ones;
            4'd8:  r = la + (la & lb);
            4'd9:  r = la + lb;
            4'd10: r = (la | nb) + (la & lb);
            4'd11: r = (la & lb) + ones;
            4'd12: r = la + la;
            4'd13: r = (la | lb) + la;
            4'd14: r = (la | nb) + la;
            default: r = la + ones;
        endcase
        r = r + longint'(c);
        case (s)
            4'd0:  lg = ~la;
            4'd1:  lg = ~(la | lb);
            4'd2:  lg = ~la & lb;
            4'd3:  lg = 0;
            4'd4:  lg = ~(la & lb);
            4'd5:  lg = nb;
            4'd6:  lg = la ^ lb;
            4'd7:  lg = la & nb;
            4'd8:  lg = ~la | lb;
            4'd9:  lg = ~(la ^ lb);
            4'd10: lg = lb;
            4'd11: lg = la & lb;
            4'd12: lg = ones;
            4'd13: lg = la | nb;
            4'd14: lg = la | lb;
            default: lg = la;
        endcase
        co = r[DW];
        f  = m ? DW'(lg & ones) : DW'(r & ones);
        eq = (longint'(f) == ones);
    endtask

    // One clock cycle: drive inputs after the falling edge, check the DUT
    // against the model, advance the model, move to the next falling edge.
    task automatic step(input logic [15:0] i, input bit w, input bit irq,
                        input logic [CW-1:0] code, input bit rdy, input logic [DW-1:0] di);
        logic [4:0]    f5;
        logic [2:0]    d;
        logic [DW-1:0] a, b, f, val;
        logic [AW-1:0] tgt, seq;
        bit            co, eq, ld, stl, isj, ret, tk, acc, wb;
        longint        la, lb, hb;
        frame_t        fr;
        instr = i; WAIT = w; INT = irq; INTCODE = code; dready = rdy; ddata_i = di;
        #1;
        stepno++;
        f5  = i[15:11];
        d   = i[10:8];
        a   = m_r[1];
        b   = m_r[2];
        tgt = {m_r[5], m_r[4], m_r[3]};
        alu_ref(i[7:4], i[3], i[2], a, b, f, co, eq);
        ld  = (f5 == 5'h04);
        stl = w || (ld && !rdy) || (m_dw && !rdy);
        isj = (f5 == 5'h01);
        ret = isj && (d == 3'd0);
        tk  = isj && ((d == 3'd1 && !a[DW-1]) || (d == 3'd2 && !b[DW-1]) ||
                      (d == 3'd3 && !eq) || (d == 3'd4 && !co));
        acc = irq && !stl && !ret && (stk.size() < EFF_D) &&
              (stk.size() == 0 || code < stk[$].code);

        chk("iaddr", iaddr, m_pc);
        chk("daddr", daddr, tgt);
        chk("ddata_o", ddata_o, m_r[7]);
        chk("dwrite", dwrite, m_dw);
        chk("dread", dread, ld);
        chk("int_ack", int_ack, acc);
        chk("int_level", int_level, stk.size());

        la = longint'(a);
        lb = longint'(b);
        hb = longint'(1) << (DW - 1);
        wb = 1'b1;
        case (f5)
            5'h02: val = f;
            5'h04: val = di;
            5'h05: val = m_r[0];
            5'h06: val = DW'(i[7:0]);
            5'h07: val = m_r[6];
            5'h0D: val = DW'(la * 2);
            5'h10: val = DW'(la * 2 + lb / hb);
            5'h12: val = DW'(la / 2);
            5'h14: val = DW'(la / 2 + (a[DW-1] ? hb : 0));
            5'h16: val = DW'(lb * 2);
            5'h18: val = DW'(lb / 2);
            5'h1A: val = DW'(lb / 2 + (b[DW-1] ? hb : 0));
            5'h1C: val = DW'(lb / 2 + (la % 2) * hb);
            default: begin wb = 1'b0; val = '0; end
        endcase

        if (m_dw && rdy) m_dw = 1'b0;
        if (!stl) begin
            seq = tk ? tgt : m_pc + AW'(1);
            if (wb) begin
                m_r[d] = val;
                if (d == 3'd7) m_dw = 1'b1;
            end
            if (acc) begin
                stk.push_back('{seq, code});
                m_pc = IVT_addr + AW'(int'(code) * 4);
            end else if (ret) begin
                if (stk.size() > 0) begin
                    fr   = stk.pop_back();
                    m_pc = fr.addr;
                end else begin
                    m_pc = '0;
                end
            end else begin
                m_pc = seq;
            end
        end
        @(negedge clk);
    endtask

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] RET = 16'h0800;

    initial begin
        int f5s [16] = '{0, 1, 2, 4, 5, 6, 7, 'h0D, 'h10, 'h12, 'h14, 'h16, 'h18, 'h1A, 'h1C, 'h1F};
        rst = 1'b1; WAIT = 1'b0; INT = 1'b0; INTCODE = '0; IVT_addr = 24'h001000;
        instr = NOP; dready = 1'b1; ddata_i = '0;
        mreset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_iaddr", iaddr, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dread", dread, 0);
        chk("rst_dwrite", dwrite, 0);
        chk("rst_ddata_o", ddata_o, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_int_level", int_level, 0);
        rst = 1'b0;

        // Ripple-carry add: 0x0F + 0x01 -> C, then C -> MDR
        step(op(6, 1, 'h0F), 0, 0, 0, 1, 0);
        step(op(6, 2, 'h01), 0, 0, 0, 1, 0);
        step(op(2, 0, 'h90), 0, 0, 0, 1, 0);
        step(op(5, 7, 0), 0, 0, 0, 1, 0);
        chk("alu_add_c", ddata_o, 8'h10);
        step(NOP, 0, 0, 0, 1, 0);

        // Load into A0 with three wait states
        repeat (3) step(op(4, 3, 0), 0, 0, 0, 0, 8'h77);
        step(op(4, 3, 0), 0, 0, 0, 1, 8'hA5);
        chk("load_a0", daddr[7:0], 8'hA5);

        // Store hold and back-to-back MDR write
        step(op(6, 7, 'h5A), 0, 0, 0, 1, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(op(6, 7, 'h33), 0, 0, 0, 0, 0);
        chk("store_hold_data", ddata_o, 8'h5A);
        chk("store_hold_dwrite", dwrite, 1);
        step(op(6, 7, 'h33), 0, 0, 0, 1, 0);
        step(NOP, 0, 0, 0, 1, 0);
        chk("store2_data", ddata_o, 8'h33);

        // Nesting: jump to 0x10, code 5, then code 2, code 7 ignored
        step(op(6, 3, 'h10), 0, 0, 0, 1, 0);
        step(op(1, 1, 0), 0, 0, 0, 1, 0);
        chk("jmp_0x10", iaddr, 24'h000010);
        step(NOP, 0, 1, 6'd5, 1, 0);
        chk("vec_code5", iaddr, 24'h001014);
        step(NOP, 0, 1, 6'd2, 1, 0);
        chk("vec_code2", iaddr, NEST ? 24'h001008 : 24'h001015);
        chk("nest_level", int_level, NEST ? 2 : 1);
        step(NOP, 0, 1, 6'd7, 1, 0);
        step(RET, 0, 0, 0, 1, 0);
        chk("ret1", iaddr, NEST ? 24'h001015 : 24'h000011);
        step(RET, 0, 0, 0, 1, 0);
        chk("ret2", iaddr, NEST ? 24'h000011 : 24'h000000);

        // Interrupt on a taken jump to 0x200
        step(op(6, 3, 'h00), 0, 0, 0, 1, 0);
        step(op(6, 4, 'h02), 0, 0, 0, 1, 0);
        step(op(1, 1, 0), 0, 1, 6'd3, 1, 0);
        chk("vec_code3", iaddr, 24'h00100C);
        step(RET, 0, 0, 0, 1, 0);
        chk("ret_to_target", iaddr, 24'h000200);

        // Full stack: codes 6, 4, 1 with depth 2
        step(NOP, 0, 1, 6'd6, 1, 0);
        step(NOP, 0, 1, 6'd4, 1, 0);
        step(NOP, 0, 1, 6'd1, 1, 0);
        step(NOP, 0, 1, 6'd1, 1, 0);
        chk("full_level", int_level, NEST ? 2 : 1);
        step(RET, 0, 1, 6'd1, 1, 0);
        step(NOP, 0, 1, 6'd1, 1, 0);
        chk("code1_level", int_level, NEST ? 2 : 1);
        repeat (3) step(RET, 0, 0, 0, 1, 0);
        chk("fault_vector", iaddr, 0);

        // WAIT beats INT, then the request is taken
        step(NOP, 1, 1, 6'd9, 1, 0);
        step(NOP, 0, 1, 6'd9, 1, 0);
        chk("wait_then_vec", iaddr, 24'h001024);
        step(RET, 0, 0, 0, 1, 0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ri;
            ri = op(f5s[$urandom_range(0, 15)], $urandom_range(0, 7), $urandom_range(0, 255));
            step(ri, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                 CW'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
                 DW'($urandom_range(0, 255)));
        end

        // Asynchronous reset in the middle of a store
        step(op(6, 7, 'hC3), 0, 0, 0, 1, 0);
        dready = 1'b0;
        #1;
        chk("store_pending", dwrite, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_dwrite", dwrite, 0);
        chk("async_rst_ddata_o", ddata_o, 0);
        chk("async_rst_level", int_level, 0);
        @(negedge clk);
        rst = 1'b0;
        mreset();
        step(op(6, 1, 'h80), 0, 0, 0, 1, 0);
        step(op(1, 1, 0), 0, 0, 0, 1, 0);
        step(NOP, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kc_ls1u_core_g2.md
# kc_ls1u_core_g2

Second-generation KC-LS1u CPU core: same 16-bit instruction set and register file, generalised to a parametrised data width, with a handshaked data bus and prioritised nested interrupts backed by a hardware return stack. It sits between the instruction ROM/cache (`iaddr`/`instr`), the data bus fabric (`daddr`/`ddata_*`/`dready`) and the interrupt controller (`INT`/`INTCODE`/`IVT_addr`).

## Interface
- `DW`, 8: datapath width; multiple of 4, ≥8. Address width `AW = 3*DW`.
- `RET_DEPTH`, 4: return-stack depth, i.e. maximum interrupt nesting; ≥1.
- `CW`, 6: interrupt-code width.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `WAIT` in 1: external stall.
- `INT` in 1: interrupt request, level.
- `INTCODE` in CW: source code of the requesting interrupt; lower code = higher priority.
- `IVT_addr` in AW: interrupt vector table base.
- `int_ack` out 1: one-cycle pulse when an interrupt is vectored.
- `int_level` out clog2(RET_DEPTH+1): current nesting depth.
- `iaddr` out AW: fetch address (= PC).
- `instr` in 16: instruction, combinational from `iaddr`.
- `daddr` out AW: `{A2,A1,A0}`.
- `dread` out 1: load in progress.
- `dwrite` out 1: store in progress.
- `ddata_i` in DW: load data.
- `ddata_o` out DW: store data (= MDR).
- `dready` in 1: data-bus completion for the current `dread`/`dwrite`.

## Operation
- **Registers:** C, A, B, A0, A1, A2, D and MDR, each DW bits. Destination codes 0–7 in that order, taken from `instr[10:8]`. All registers reset to 0.
- **funct5 (`instr[15:11]`):**
  - 01 JMP.
  - 02 ALU → dst.
  - 04 LOAD MEM.
  - 05 MOV C.
  - 06 LI, with `instr[7:0]` zero-extended.
  - 07 MOV D.
  - Shifts:
    - 0D: A<<1.
    - 10: {A[DW-2:0], B[DW-1]}.
    - 12: A>>1.
    - 14: A arithmetic >>1.
    - 16: B<<1.
    - 18: B>>1.
    - 1A: B arithmetic >>1.
    - 1C: {A[0], B[DW-1:1]}.
  - All other values are NOP.
- **ALU:**
  - DW/4 74181 slices with ripple carry: slice k `cin` = slice k-1 `cout`; slice 0 takes `instr[2]`.
  - S = `instr[7:4]`, M = `instr[3]`.
  - Co = top-slice `cout`; EQ = AND of all slice `eqv`.
- **JMP (`instr[10:8]`):**
  - 0: RET.
  - 1: jump if !A[DW-1].
  - 2: jump if !B[DW-1].
  - 3: jump if !EQ.
  - 4: jump if !Co.
  - 5–7: NOP.
  - Jump target is `{A2,A1,A0}`.
- **Stores:**
  - Any write to MDR sets `dwrite` on the next cycle.
  - `dwrite` holds until a cycle with `dready`=1, then clears.
- **Loads:**
  - `dread` = 1 combinationally while LOAD MEM is decoded.
  - Writeback happens in the cycle where `dready`=1.
- **Stall:** asserted when `WAIT`, or (`dread` and !`dready`), or (`dwrite` and !`dready`).
  - PC holds; no register writeback.
  - No interrupt is accepted.
- **Interrupt acceptance:** a cycle accepts an interrupt when all of the following hold:
  - `INT`=1.
  - Not stalled.
  - Current instruction is not RET.
  - `int_level` < RET_DEPTH.
  - Either `int_level`=0 or `INTCODE` < code on top of the stack.
- **On acceptance:**
  - Push {return address, `INTCODE`}. Return address = jump target if the current instruction jumps, else PC+1.
  - PC ← `IVT_addr + (INTCODE<<2)`.
  - `int_level`+1; `int_ack` = 1.
  - The current instruction's register writeback still completes.
- **RET:**
  - With `int_level`>0: PC ← popped address; `int_level`−1.
  - With `int_level`=0: PC ← 0. This is the defined fault vector.
- **Rejected requests:** a request rejected for priority or a full stack is not latched. The interrupt controller holds `INT`.

## Timing
- One instruction per cycle when not stalled; PC, registers and stack update on `posedge clk`.
- Loads have zero wait states if `dready` is high in the decode cycle; each low cycle adds one stall.
- A store occupies the bus from the cycle after the MDR write until `dready`. Back-to-back MDR writes stall the second until the first completes.
- Reset values, all 0: `iaddr`, `daddr`, `dread`, `dwrite`, `ddata_o`, `int_ack`, `int_level`, and the stack.
- Reset mid-stall or mid-store drops `dwrite` immediately (asynchronous).
- `int_ack` is high only in the accepting cycle; PC shows the vector the following cycle.
- `WAIT` together with `INT`: the stall wins, and the interrupt is evaluated again after the stall.

## Configuration
- `KC_LS1U_G2_NEST_EN` defined: nested, prioritised interrupts as described above.
- `KC_LS1U_G2_NEST_EN` undefined:
  - Effective RET_DEPTH = 1 and the priority compare is removed.
  - Interrupts are masked from acceptance until RET.
  - Return address is still jump-aware.
  - `int_level` is 0 or 1.

## Test plan
- **Reset and arithmetic:** reset, then LI A=0x0F, LI B=0x01, ALU add (S=9, M=0, cin=0) → C.
  - DW=8: C=0x10 (ripple-carry check).
  - DW=16 with A=0x00FF: C=0x0100.
- **Load wait states:** LOAD MEM with `dready` low for 3 cycles. PC holds 3 cycles and the register is written in cycle 4 with `ddata_i`=0xA5; `dread` high for 4 cycles.
- **Store hold:** write MDR=0x5A. `dwrite` rises the next cycle and holds through 2 low-`dready` cycles; `ddata_o`=0x5A; the following MDR write stalls until then.
- **Nesting:** `INT` with code 5 at PC=0x10, then code 2 inside the ISR.
  - Vectors: `IVT_addr`+0x14, then `IVT_addr`+0x08; `int_level` = 2.
  - Code 7 requested at depth 2 is ignored.
  - Two RETs return to ISR+1, then 0x11.
- **Interrupt on a taken jump:** `INT` during a taken JMP to 0x200 → pushed address 0x200, not PC+1.
- **Full stack:** RET_DEPTH=2, three nested codes 6, 4, 1. The third is not acked until one RET; `int_level` never exceeds 2.
